display_writer: RTL and testbench



---
 rtl/display_writer.sv | 153 +++++++++++++++
 tb/tb_display_writer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/display_writer.sv
// Binary-to-BCD display writer: double-dabble conversion, then one dig/pos write per cycle.
// Optional ZERO_SUPPRESS_EN blanks leading zeros (dig=4'hF) while keeping EMIT timing.
module display_writer #(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned VALUE_W = 27
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [3:0]         dig,
  output logic [3:0]         pos
);

  localparam int unsigned BcdW    = 4 * DIGITS;
  localparam int unsigned BitCntW = $clog2(VALUE_W + 1);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MaxVal = pow10(DIGITS) - 1;

  typedef enum logic [2:0] {StIdle, StConvert, StEmit, StOvf, StDone} state_e;

  state_e               state_q;
  logic [VALUE_W-1:0]   bin_q;
  logic [BcdW-1:0]      bcd_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [3:0]           pos_cnt_q;

  logic                 value_ovf;
  logic [BcdW-1:0]      bcd_adj;
  logic [BcdW-1:0]      bcd_shift;
  logic [VALUE_W-1:0]   bin_shift;
  logic [3:0]           cur_nib;
  logic [3:0]           emit_dig;

  assign value_ovf = 64'(value) > MaxVal;

  // Add-3 per nibble (no inter-nibble carry), then shift {bcd, bin} left by one.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    bcd_shift = {bcd_adj[BcdW-2:0], bin_q[VALUE_W-1]};
    bin_shift = {bin_q[VALUE_W-2:0], 1'b0};
  end

`ifdef ZERO_SUPPRESS_EN
  logic [DIGITS-1:0] zero_from;
  logic              zero_acc;
  logic              cur_blank;

  // zero_from[i]: every nibble at position i and above is zero.
  always_comb begin
    zero_from = '0;
    zero_acc  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_acc     = zero_acc & (bcd_q[4*i +: 4] == 4'd0);
      zero_from[i] = zero_acc;
    end
  end

  always_comb begin
    cur_nib   = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (pos_cnt_q == 4'(i)) begin
        cur_nib   = bcd_q[4*i +: 4];
        cur_blank = (i != 0) && zero_from[i];
      end
    end
    emit_dig = cur_blank ? 4'hF : cur_nib;
  end
`else
  always_comb begin
    cur_nib = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (pos_cnt_q == 4'(i)) cur_nib = bcd_q[4*i +: 4];
    end
    emit_dig = cur_nib;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      pos_cnt_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      dig       <= 4'hF;
      pos       <= 4'hF;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          dig  <= 4'hF;
          pos  <= 4'hF;
          busy <= 1'b0;
          if (start) begin
            bin_q     <= value;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            pos_cnt_q <= '0;
            busy      <= 1'b1;
            overflow  <= value_ovf;
            state_q   <= value_ovf ? StOvf : StConvert;
          end
        end
        StConvert: begin
          bin_q     <= bin_shift;
          bcd_q     <= bcd_shift;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitCntW'(VALUE_W - 1)) begin
            pos_cnt_q <= '0;
            state_q   <= StEmit;
          end
        end
        StEmit: begin
          pos       <= pos_cnt_q;
          dig       <= emit_dig;
          pos_cnt_q <= pos_cnt_q + 4'd1;
          if (pos_cnt_q == 4'(DIGITS - 1)) state_q <= StDone;
        end
        StOvf: begin
          state_q <= StDone;
        end
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          dig     <= 4'hF;
          pos     <= 4'hF;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_writer.sv
// Self-checking bench for display_writer: directed and random values against a decimal model.
module tb_display_writer;

  localparam int DIGITS  = 8;
  localparam int VALUE_W = 27;
  localparam int WR_LAT  = VALUE_W + 1;
  localparam int DONE_LAT = VALUE_W + DIGITS + 1;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [VALUE_W-1:0] value = '0;
  logic               busy, done, overflow;
  logic [3:0]         dig, pos;

  display_writer #(.DIGITS(DIGITS), .VALUE_W(VALUE_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .overflow(overflow),
    .dig     (dig),
    .pos     (pos)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int       cyc;
    logic [3:0] pos;
    logic [3:0] dig;
  } act_t;
  act_t acts[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Any non-idle output code is logged; a real write must only appear while busy.
  always @(negedge clock) begin
    if (!reset) begin
      if (pos != 4'hF || dig != 4'hF) acts.push_back('{cyc, pos, dig});
      if (pos < 4'd8 && dig < 4'd10) check("write_outside_emit", 64'(busy), 64'd1);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] exp_dig(input longint v, input int k);
    longint p = 1;
    longint d;
    for (int i = 0; i < k; i++) p = p * 10;
    d = (v / p) % 10;
`ifdef ZERO_SUPPRESS_EN
    if (k > 0 && v < p) return 4'hF;
`endif
    return d[3:0];
  endfunction

  // hold7: keep start=1 with value 7 asserted for the whole sequence.
  task automatic run(input longint v, input bit hold7);
    int  e0;
    int  dcyc;
    bit  ovf;
    int  nexp;
    ovf  = v > 64'd99999999;
    nexp = ovf ? 0 : DIGITS;
    acts.delete();
    start = 1'b1;
    value = VALUE_W'(v);
    step();
    e0 = cyc;
    if (hold7) begin
      value = VALUE_W'(7);
    end else begin
      start = 1'b0;
      value = VALUE_W'($urandom);
    end
    check("busy_after_start", 64'(busy), 64'd1);
    dcyc = -1;
    for (int i = 0; i < 60 && dcyc < 0; i++) begin
      if (done) dcyc = cyc;
      else step();
    end
    check("done_latency", 64'(dcyc - e0), 64'(ovf ? 2 : DONE_LAT));
    check("overflow_flag", 64'(overflow), 64'(ovf));
    check("busy_at_done", 64'(busy), 64'd0);
    check("num_writes", 64'(acts.size()), 64'(nexp));
    for (int k = 0; k < acts.size() && k < nexp; k++) begin
      check("write_pos", 64'(acts[k].pos), 64'(k));
      check("write_dig", 64'(acts[k].dig), 64'(exp_dig(v, k)));
      check("write_cycle", 64'(acts[k].cyc - e0), 64'(WR_LAT + k));
    end
    if (!hold7) begin
      step();
      check("done_one_cycle", 64'(done), 64'd0);
    end
  endtask

  initial begin
    int  seen;
    reset = 1'b1;
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_dig", 64'(dig), 64'hF);
    check("rst_pos", 64'(pos), 64'hF);
    reset = 1'b0;
    step();

    run(12345678, 1'b0);
    run(0, 1'b0);
    run(99999999, 1'b0);
    run(100000000, 1'b0);
    repeat (3) step();
    check("overflow_held", 64'(overflow), 64'd1);

    for (int n = 0; n < 4; n++) run(longint'($urandom_range(0, 99999999)), 1'b0);
    for (int n = 0; n < 2; n++) run(longint'($urandom_range(100000000, 134217727)), 1'b0);
    run(longint'($urandom_range(1, 999)), 1'b0);

    // 7 is held through the 42 sequence and only taken once back in idle.
    run(42, 1'b1);
    run(7, 1'b0);

    start = 1'b1;
    value = VALUE_W'($urandom_range(10000000, 99999999));
    step();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      if (pos == 4'd3) seen = 1;
      else step();
    end
    check("reached_pos3", 64'(seen), 64'd1);
    reset = 1'b1;
    step();
    check("midrst_pos", 64'(pos), 64'hF);
    check("midrst_dig", 64'(dig), 64'hF);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    acts.delete();
    repeat (40) step();
    check("no_writes_after_reset", 64'(acts.size()), 64'd0);
    check("idle_after_reset", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
